// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter and its round-robin picker.
// The FSM state encoding and the default parameter values live here.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick
// Combinational round-robin picker. The search starts at last_winner+1 and
// wraps cyclically, so the most recent winner has the lowest priority.
// Ports:
//   req         in  NREQ  request vector
//   last_winner in  3     index of the previous winner
//   winner      out 3     index of the selected requester (0 when none)
//   valid       out 1     high when at least one request is pending
import fifo_arb_pkg::*;

module fifo_rr_pick #(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last_winner,
    output logic [2:0]      winner,
    output logic            valid
);

    int start_idx;

    // The outer loop walks priority order; the inner loop keeps every req
    // index constant so only fixed bit selects are generated.
    always_comb begin
        winner    = '0;
        valid     = 1'b0;
        start_idx = int'(last_winner);
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!valid && req[j] && (j == ((start_idx + k) % NREQ))) begin
                    winner = 3'(j);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the write port of a FIFO between NREQ
// requesters. A winner is chosen in IDLE and then owns the port for a burst
// of up to MAX_BURST words. The write enable and write data are registered.
// Ports:
//   Clk            in  1        write-side clock
//   Reset_n        in  1        asynchronous active-low reset
//   req            in  NREQ     per-requester request (word valid)
//   req_data       in  NREQ*DW  packed data lanes, lane i = [i*DW +: DW]
//   gnt            out NREQ     one-hot word-accept strobe (combinational)
//   fifo_full      in  1        FIFO write-side full flag
//   fifo_wr_enable out 1        registered FIFO write strobe
//   fifo_wr_data   out DW       registered FIFO write data
//   busy           out 1        high while a burst is in progress
//   owner          out 3        current or last burst owner
import fifo_arb_pkg::*;

module fifo_wr_arbiter #(
    parameter int NREQ      = NREQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  gnt,
    input  logic             fifo_full,
    output logic             fifo_wr_enable,
    output logic [DW-1:0]    fifo_wr_data,
    output logic             busy,
    output logic [2:0]       owner
);

    arb_state_e    state_q, state_d;
    logic [2:0]    owner_q, owner_d;
    logic [3:0]    burst_cnt_q, burst_cnt_d;
    logic [2:0]    last_winner_q, last_winner_d;
    logic          fifo_wr_enable_q, fifo_wr_enable_d;
    logic [DW-1:0] fifo_wr_data_q, fifo_wr_data_d;

    logic          owner_req;
    logic [DW-1:0] owner_lane;
    logic          word_acc;
    logic [2:0]    pick_winner;
    logic          pick_valid;

    fifo_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req         (req),
        .last_winner (last_winner_q),
        .winner      (pick_winner),
        .valid       (pick_valid)
    );

    // Request and data lane of the current owner.
    always_comb begin
        owner_req  = 1'b0;
        owner_lane = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == 3'(i)) begin
                owner_req  = req[i];
                owner_lane = req_data[i*DW +: DW];
            end
        end
    end

    // Only the owner can be granted, and only while the FIFO has room.
    always_comb begin
        gnt = '0;
        if (state_q == BURST) begin
            for (int i = 0; i < NREQ; i++) begin
                if (owner_q == 3'(i)) begin
                    gnt[i] = req[i] & ~fifo_full;
                end
            end
        end
    end

    assign word_acc = |gnt;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        burst_cnt_d      = burst_cnt_q;
        last_winner_d    = last_winner_q;
        fifo_wr_enable_d = 1'b0;
        fifo_wr_data_d   = fifo_wr_data_q;

        case (state_q)
            IDLE: begin
                if (pick_valid && !fifo_full) begin
                    owner_d     = pick_winner;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (word_acc) begin
                    fifo_wr_enable_d = 1'b1;
                    fifo_wr_data_d   = owner_lane;
                    burst_cnt_d      = burst_cnt_q + 4'd1;
                end
                // A dropped request ends the burst even while the FIFO is full;
                // the counter is cleared on the terminal word so it stays below
                // MAX_BURST.
                if ((word_acc && (burst_cnt_q == 4'(MAX_BURST - 1))) || !owner_req) begin
                    state_d       = IDLE;
                    last_winner_d = owner_q;
                    burst_cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q          <= IDLE;
            owner_q          <= '0;
            burst_cnt_q      <= '0;
            last_winner_q    <= 3'(NREQ - 1);
            fifo_wr_enable_q <= 1'b0;
            fifo_wr_data_q   <= '0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            burst_cnt_q      <= burst_cnt_d;
            last_winner_q    <= last_winner_d;
            fifo_wr_enable_q <= fifo_wr_enable_d;
            fifo_wr_data_q   <= fifo_wr_data_d;
        end
    end

    assign fifo_wr_enable = fifo_wr_enable_q;
    assign fifo_wr_data   = fifo_wr_data_q;
    assign busy           = (state_q == BURST);
    assign owner          = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Directed and randomised checks of fifo_wr_arbiter with NREQ=4, DW=8,
// MAX_BURST=4.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic               Clk;
    logic               Reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               fifo_full;
    logic               fifo_wr_enable;
    logic [DW-1:0]      fifo_wr_data;
    logic               busy;
    logic [2:0]         owner;

    int n_tests;
    int n_fail;
    int wc [NREQ];
    int exp_own [5];
    int own;
    logic [NREQ-1:0] pg;
    logic [DW-1:0]   pl;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .req            (req),
        .req_data       (req_data),
        .gnt            (gnt),
        .fifo_full      (fifo_full),
        .fifo_wr_enable (fifo_wr_enable),
        .fifo_wr_data   (fifo_wr_data),
        .busy           (busy),
        .owner          (owner)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_lane(input int i, input int v);
        req_data[i*DW +: DW] = DW'(v);
    endtask

    task automatic do_reset();
        req       = '0;
        fifo_full = 1'b0;
        req_data  = '0;
        Reset_n   = 1'b0;
        step();
        Reset_n   = 1'b1;
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        Reset_n   = 1'b0;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        repeat (2) step();

        // Reset state
        chk("rst_we",    32'(fifo_wr_enable), 0);
        chk("rst_data",  32'(fifo_wr_data),   0);
        chk("rst_gnt",   32'(gnt),            0);
        chk("rst_busy",  32'(busy),           0);
        chk("rst_owner", 32'(owner),          0);
        Reset_n = 1'b1;
        #1;

        // Single requester: 4-word burst, then re-arbitration for the 5th word
        req = 4'b0001;
        set_lane(0, 'hA0);
        #1;
        chk("s_idle_gnt",  32'(gnt),  0);
        chk("s_idle_busy", 32'(busy), 0);
        step();
        chk("s_busy",  32'(busy),           1);
        chk("s_owner", 32'(owner),          0);
        chk("s_we0",   32'(fifo_wr_enable), 0);
        for (int w = 0; w < 4; w++) begin
            chk("s_gnt", 32'(gnt), 1);
            step();
            chk("s_we",   32'(fifo_wr_enable), 1);
            chk("s_data", 32'(fifo_wr_data),   'hA0 + w);
            set_lane(0, 'hA0 + w + 1);
            #1;
        end
        chk("s_end_busy", 32'(busy), 0);
        chk("s_end_gnt",  32'(gnt),  0);
        step();
        chk("s_re_busy",  32'(busy),           1);
        chk("s_re_owner", 32'(owner),          0);
        chk("s_re_we",    32'(fifo_wr_enable), 0);
        chk("s_re_gnt",   32'(gnt),            1);
        step();
        chk("s_a4_we",   32'(fifo_wr_enable), 1);
        chk("s_a4_data", 32'(fifo_wr_data),   'hA4);
        req = 4'b0000;
        #1;
        step();
        chk("s_drop_busy", 32'(busy),           0);
        chk("s_drop_we",   32'(fifo_wr_enable), 0);

        // All four requesting: bursts 0,1,2,3,0 of 4 words each
        do_reset();
        exp_own = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            wc[i] = 0;
            set_lane(i, i * 16);
        end
        req = 4'b1111;
        #1;
        for (int b = 0; b < 5; b++) begin
            chk("rr_idle_busy", 32'(busy), 0);
            chk("rr_idle_gnt",  32'(gnt),  0);
            step();
            own = exp_own[b];
            for (int w = 0; w < 4; w++) begin
                if (w == 0) chk("rr_arb_we", 32'(fifo_wr_enable), 0);
                chk("rr_owner", 32'(owner), own);
                chk("rr_busy",  32'(busy),  1);
                chk("rr_gnt",   32'(gnt),   32'(1) << own);
                step();
                chk("rr_we",   32'(fifo_wr_enable), 1);
                chk("rr_data", 32'(fifo_wr_data),   own * 16 + wc[own]);
                wc[own]++;
                set_lane(own, own * 16 + wc[own]);
                #1;
            end
        end

        // Requester 2 stalled by fifo_full after its second word
        do_reset();
        req = 4'b0100;
        set_lane(2, 'hC0);
        #1;
        step();
        for (int w = 0; w < 2; w++) begin
            chk("st_gnt", 32'(gnt), 4);
            step();
            chk("st_data", 32'(fifo_wr_data), 'hC0 + w);
            set_lane(2, 'hC0 + w + 1);
        end
        fifo_full = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("st_full_gnt",   32'(gnt),   0);
            chk("st_full_busy",  32'(busy),  1);
            chk("st_full_owner", 32'(owner), 2);
            step();
            chk("st_full_we",   32'(fifo_wr_enable), 0);
            chk("st_full_data", 32'(fifo_wr_data),   'hC1);
        end
        fifo_full = 1'b0;
        #1;
        for (int w = 2; w < 4; w++) begin
            chk("st_res_gnt", 32'(gnt), 4);
            step();
            chk("st_res_we",   32'(fifo_wr_enable), 1);
            chk("st_res_data", 32'(fifo_wr_data),   'hC0 + w);
            set_lane(2, 'hC0 + w + 1);
            #1;
        end
        chk("st_end_busy", 32'(busy), 0);

        // Requester 1 drops early; next burst goes to 3, not 0
        do_reset();
        req = 4'b1010;
        set_lane(1, 'hD0);
        set_lane(3, 'hE0);
        #1;
        step();
        chk("dr_owner1", 32'(owner), 1);
        for (int w = 0; w < 2; w++) begin
            chk("dr_gnt", 32'(gnt), 2);
            step();
            chk("dr_data", 32'(fifo_wr_data), 'hD0 + w);
            set_lane(1, 'hD0 + w + 1);
        end
        req = 4'b1001;
        #1;
        chk("dr_drop_gnt",  32'(gnt),  0);
        chk("dr_drop_busy", 32'(busy), 1);
        step();
        chk("dr_idle_busy", 32'(busy),           0);
        chk("dr_idle_we",   32'(fifo_wr_enable), 0);
        step();
        chk("dr_owner3", 32'(owner), 3);
        chk("dr_gnt3",   32'(gnt),   8);
        step();
        chk("dr_data3", 32'(fifo_wr_data), 'hE0);

        // Asynchronous reset mid-burst
        do_reset();
        req = 4'b0001;
        set_lane(0, 'hF0);
        #1;
        step();
        for (int w = 0; w < 2; w++) begin
            step();
            chk("ar_data", 32'(fifo_wr_data), 'hF0 + w);
            set_lane(0, 'hF0 + w + 1);
        end
        chk("ar_busy_pre", 32'(busy), 1);
        Reset_n = 1'b0;
        #1;
        chk("ar_we",    32'(fifo_wr_enable), 0);
        chk("ar_data0", 32'(fifo_wr_data),   0);
        chk("ar_gnt",   32'(gnt),            0);
        chk("ar_busy",  32'(busy),           0);
        chk("ar_owner", 32'(owner),          0);
        req = 4'b0101;
        step();
        Reset_n = 1'b1;
        #1;
        step();
        chk("ar_rel_owner", 32'(owner), 0);
        chk("ar_rel_busy",  32'(busy),  1);
        chk("ar_rel_gnt",   32'(gnt),   1);

        // Random req / fifo_full with a word scoreboard
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            wc[i] = 0;
            set_lane(i, i * 64);
        end
        for (int c = 0; c < 1000; c++) begin
            req       = 4'($urandom_range(15));
            fifo_full = ($urandom_range(3) == 0);
            #1;
            chk("rnd_onehot", 32'($countones(gnt) <= 1), 1);
            chk("rnd_full",   32'(gnt & {NREQ{fifo_full}}), 0);
            pg = gnt;
            pl = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (pg[i]) pl = req_data[i*DW +: DW];
            end
            step();
            chk("rnd_we", 32'(fifo_wr_enable), 32'(|pg));
            if (|pg) chk("rnd_data", 32'(fifo_wr_data), 32'(pl));
            for (int i = 0; i < NREQ; i++) begin
                if (pg[i]) begin
                    wc[i] = (wc[i] + 1) % 64;
                    set_lane(i, i * 64 + wc[i]);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Single-clock round-robin arbiter that shares the write port of the 16×8 FIFO between NREQ requesters. Grants bursts of up to MAX_BURST words to one requester at a time, honours the FIFO's write-side full flag, and drives the FIFO write enable and data from registers. Sits in the FIFO write-clock domain, directly in front of the FIFO write port.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DW, 8: data width; matches the FIFO word.
- MAX_BURST, 4: maximum words per grant, 1..16.

- Clk  in  1  write-side clock; all logic on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; held high while the requester has a valid word on its data lane.
- req_data  in  NREQ*DW  packed data lanes; lane i = bits [i*DW +: DW].
- gnt  out  NREQ  one-hot word-accept strobe; combinational.
- fifo_full  in  1  FIFO write-side full flag.
- fifo_wr_enable  out  1  registered write strobe to the FIFO.
- fifo_wr_data  out  DW  registered write data to the FIFO.
- busy  out  1  high in BURST state.
- owner  out  3  index of the current or last burst owner.

## Operation
- Reset values: fifo_wr_enable 0, fifo_wr_data 0, gnt 0, busy 0, owner 0, burst_cnt 0, state IDLE. The last-winner pointer resets to NREQ-1, so requester 0 has top priority on the first arbitration.
- **IDLE**:
  - If any req is high and fifo_full is 0, pick the first requester with req high, searching cyclically from last_winner+1.
  - Load owner with the winner, clear burst_cnt, go to BURST.
  - No gnt is issued in IDLE; every burst costs one arbitration cycle.
  - If fifo_full is 1, stay in IDLE even when requests are pending.
- **BURST**:
  - gnt[owner] = req[owner] & ~fifo_full. All other gnt bits are 0.
  - A word is accepted when gnt[owner] is 1. Then burst_cnt increments, fifo_wr_data <= lane[owner], and fifo_wr_enable <= 1. Otherwise fifo_wr_enable <= 0 and fifo_wr_data holds.
  - Return to IDLE and set last_winner <= owner when either condition holds:
    - a word is accepted with burst_cnt == MAX_BURST-1;
    - req[owner] is 0, checked regardless of fifo_full.
  - While fifo_full is 1 and req[owner] is 1, the arbiter stalls in BURST with no gnt. There is no timeout.
- A requester samples gnt. When gnt[i] is 1 at a clock edge, the lane word is consumed, and the requester either presents its next word or drops req.
- burst_cnt is a 4-bit counter and never exceeds MAX_BURST-1.
- Requests from non-owners are ignored until the next IDLE cycle.
- If Reset_n is asserted mid-burst, all state and outputs return to reset values immediately. A word accepted on the last edge before reset but not yet written by the FIFO is lost.

## Timing
- Latency from a gnt[i] edge to fifo_wr_enable high with that word: 1 cycle.
- Minimum request-to-first-gnt latency: 1 cycle (one IDLE arbitration cycle).
- Sustained throughput: MAX_BURST words per MAX_BURST+1 cycles under contention.
- fifo_full is sampled combinationally into gnt. The FIFO asserts full at count > 12, so the 1-cycle registered path cannot overflow the FIFO.
- Fairness: with all NREQ requesters continuously requesting, each receives exactly one burst per NREQ bursts, in cyclic order.

## Structure
- Shared package fifo_arb_pkg holds:
  - the state enum: IDLE=1'b0, BURST=1'b1;
  - default parameter constants NREQ_DEF, DW_DEF, MAX_BURST_DEF.
- Sub-module fifo_rr_pick: a combinational round-robin picker.
  - Inputs: req vector and last_winner.
  - Outputs: winner index and a valid flag.
  - Reusable for the read-side scheduler.
- Top level holds the FSM, burst_cnt, last_winner, and the output registers.

## Test plan
- After reset, req=4'b0001 with lane0 = 0xA0, 0xA1, 0xA2, 0xA3, 0xA4 → gnt[0] on cycles 2-5, fifo_wr_enable on cycles 3-6 with 0xA0..0xA3. The arbiter then returns to IDLE, re-grants requester 0, and 0xA4 follows.
- req=4'b1111 held continuously with MAX_BURST=4 → bursts in order 0,1,2,3,0. Each burst is exactly 4 words followed by 1 idle cycle.
- Requester 2 bursting, fifo_full raised for 5 cycles after its second word → gnt=0 and fifo_wr_enable=0 during the stall, state stays BURST, owner stays 2. Words 3-4 resume when full drops.
- Requester 1 drops req after 2 words while requester 3 is requesting → arbiter returns to IDLE. The next burst goes to requester 3 with last_winner=1.
- Reset_n pulsed low mid-burst (after 2 words) → all outputs are 0 immediately and owner is 0. On release, requester 0 wins if requesting.
- Scoreboard over 1000 random req and fifo_full cycles:
  - every accepted word appears at fifo_wr_data exactly once, in order, one cycle later;
  - gnt is never asserted while fifo_full is 1;
  - gnt always has at most one bit set.
